pc_nzp_stack_unit: RTL
======================

Name: pc_nzp_stack_unit

Overview:
- Parametrised next-generation program-counter / condition-flag unit, one instance per thread lane in the core.
- Computes the next PC during EXECUTE and holds the NZP flags, updated during UPDATE.
- Adds to the base unit: configurable widths, signed-arithmetic NZP derivation, PC-relative branches, and a CALL/RET return-address stack.
- Adds sticky overflow/underflow fault reporting and a one-cycle next-PC-valid strobe.

Parameters:
- PC_WIDTH, 8, width of PC, immediate and return-stack entries.
- DATA_WIDTH, 8, width of ALU result used for NZP derivation.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- SP_WIDTH, $clog2(STACK_DEPTH+1), width of the stack occupancy count.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  lane enable; when low, all state holds.
- core_state  input  3  scheduler state; 3'b101 = EXECUTE, 3'b110 = UPDATE, others idle.
- current_pc  input  PC_WIDTH  PC of the instruction in flight.
- alu_out  input  DATA_WIDTH  ALU result (CMP/arith) for NZP update.
- imm  input  PC_WIDTH  branch/call target (absolute) or signed offset (relative).
- decoded_nzp  input  3  branch condition mask {N,Z,P}.
- nzp_write_enable  input  1  qualifies NZP update in UPDATE.
- pc_op  input  3  000 SEQ, 001 BR_ABS, 010 BR_REL, 011 CALL, 100 RET; 101-111 treated as SEQ.
- next_pc  output  PC_WIDTH  computed next PC (registered).
- nzp_flags  output  3  {N,Z,P} (registered).
- next_pc_valid  output  1  one-cycle strobe: next_pc updated.
- branch_taken  output  1  registered with next_pc: non-sequential PC chosen.
- stack_count  output  SP_WIDTH  current return-stack occupancy.
- fault  output  2  sticky; [0] = stack overflow, [1] = stack underflow.

Behaviour:
- Reset (async, any time incl. mid-operation) gives: next_pc=0, nzp_flags=0, next_pc_valid=0, branch_taken=0, stack_count=0, fault=0. Stack contents are don't-care.
- All updates occur on the rising clk edge, and only when enable=1. With enable=0, every register holds and next_pc_valid=0 on the next cycle.
- EXECUTE (enable=1, core_state=3'b101): next_pc, branch_taken and stack are updated at the edge; next_pc_valid=1 for exactly the following cycle, 0 otherwise. Latency is 1 cycle.
- cond = |(nzp_flags & decoded_nzp), using the registered flags (no same-cycle forwarding). decoded_nzp=000 is never taken.
- SEQ: next_pc = current_pc+1; branch_taken=0.
- BR_ABS: if cond, next_pc=imm and branch_taken=1; else SEQ.
- BR_REL: if cond, next_pc = current_pc + imm (imm two's-complement, PC_WIDTH bits) and branch_taken=1; else SEQ.
- CALL (unconditional):
  - If stack_count<STACK_DEPTH: push current_pc+1, stack_count+1, next_pc=imm, branch_taken=1.
  - If full: no push, next_pc=current_pc+1, branch_taken=0, fault[0]<=1.
- RET (unconditional):
  - If stack_count>0: pop top, next_pc=popped value, stack_count-1, branch_taken=1.
  - If empty: next_pc=current_pc+1, branch_taken=0, fault[1]<=1.
- All PC arithmetic is modulo 2^PC_WIDTH: wrap 0xFF+1 -> 0x00 for 8 bits; relative branches wrap both directions.
- Stack is LIFO; push and pop are mutually exclusive per cycle (single pc_op).
- UPDATE (enable=1, core_state=3'b110, nzp_write_enable=1): derive flags from alu_out as signed:
  - N = alu_out[DATA_WIDTH-1].
  - Z = (alu_out==0).
  - P = !N & !Z.
  - nzp_flags <= {N,Z,P}; exactly one bit is set.
- UPDATE with nzp_write_enable=0 leaves flags unchanged.
- Other core_state values: no state change; next_pc_valid=0.
- Fault bits are sticky until reset; the unit keeps operating after a fault.

Test Plan:
- Reset async mid-EXECUTE with stack_count=2 -> all outputs 0 immediately, without waiting for a clock edge; stack_count=0.
- UPDATE with alu_out=8'hF6 (-10) -> nzp_flags=100. Then EXECUTE BR_ABS imm=8'h40, decoded_nzp=100 -> next_pc=8'h40, branch_taken=1, next_pc_valid pulses 1 cycle. Same with decoded_nzp=011 -> next_pc=current_pc+1.
- BR_REL taken, current_pc=8'h05, imm=8'hFD -> next_pc=8'h02; current_pc=8'hFF with SEQ -> next_pc=8'h00.
- CALL at pc 8'h10 imm 8'h80, then RET -> next_pc 8'h80 then 8'h11; nested CALLs return in LIFO order; stack_count tracks 1,2,1,0.
- STACK_DEPTH+1 CALLs -> fault[0]=1, last call yields current_pc+1, count stays STACK_DEPTH. RET on empty -> fault[1]=1, next_pc=current_pc+1.
- enable=0 during EXECUTE/UPDATE -> next_pc, flags, stack unchanged; next_pc_valid=0.

Source files
------------

// File: rtl/pc_nzp_stack_unit_if.sv
// rtl/pc_nzp_stack_unit_if.sv - scheduler-facing bus of the PC / NZP / return-stack lane unit
interface pc_nzp_stack_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
);
  logic                  enable;
  logic [2:0]            core_state;
  logic [PC_WIDTH-1:0]   current_pc;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [PC_WIDTH-1:0]   imm;
  logic [2:0]            decoded_nzp;
  logic                  nzp_write_enable;
  logic [2:0]            pc_op;

  logic [PC_WIDTH-1:0]   next_pc;
  logic [2:0]            nzp_flags;
  logic                  next_pc_valid;
  logic                  branch_taken;
  logic [SP_WIDTH-1:0]   stack_count;
  logic [1:0]            fault;

  modport master (
    output enable, core_state, current_pc, alu_out, imm, decoded_nzp, nzp_write_enable, pc_op,
    input  next_pc, nzp_flags, next_pc_valid, branch_taken, stack_count, fault
  );

  modport slave (
    input  enable, core_state, current_pc, alu_out, imm, decoded_nzp, nzp_write_enable, pc_op,
    output next_pc, nzp_flags, next_pc_valid, branch_taken, stack_count, fault
  );
endinterface

// File: rtl/pc_nzp_stack_unit.sv
// rtl/pc_nzp_stack_unit.sv - per-lane next-PC / NZP flag unit with CALL/RET return stack
module pc_nzp_stack_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
  input logic clk,
  input logic reset,
  pc_nzp_stack_unit_if.slave bus
);

  localparam logic [2:0] ST_EXECUTE = 3'b101;
  localparam logic [2:0] ST_UPDATE  = 3'b110;

  localparam logic [2:0] OP_BR_ABS = 3'b001;
  localparam logic [2:0] OP_BR_REL = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_WIDTH-1:0] DEPTH_CNT = SP_WIDTH'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] next_pc_q;
  logic [2:0]          nzp_q;
  logic                valid_q;
  logic                taken_q;
  logic [SP_WIDTH-1:0] count_q;
  logic [1:0]          fault_q;

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic                exec_fire;
  logic                upd_fire;
  logic                cond;
  logic                stack_full;
  logic                stack_empty;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [SP_WIDTH-1:0] count_dec;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    pop_idx;

  logic [PC_WIDTH-1:0] exec_pc;
  logic                exec_taken;
  logic                do_push;
  logic                do_pop;
  logic                ovf;
  logic                unf;

  logic                flag_n;
  logic                flag_z;
  logic                flag_p;

  assign exec_fire   = bus.enable && (bus.core_state == ST_EXECUTE);
  assign upd_fire    = bus.enable && (bus.core_state == ST_UPDATE) && bus.nzp_write_enable;

  // Branch condition uses the registered flags only; no forwarding from a same-cycle UPDATE.
  assign cond        = |(nzp_q & bus.decoded_nzp);
  assign stack_full  = (count_q == DEPTH_CNT);
  assign stack_empty = (count_q == '0);
  assign seq_pc      = bus.current_pc + PC_WIDTH'(1);
  assign count_dec   = count_q - SP_WIDTH'(1);
  assign push_idx    = count_q[IDX_W-1:0];
  assign pop_idx     = count_dec[IDX_W-1:0];

  assign flag_n = bus.alu_out[DATA_WIDTH-1];
  assign flag_z = (bus.alu_out == '0);
  assign flag_p = !flag_n && !flag_z;

  always_comb begin
    exec_pc    = seq_pc;
    exec_taken = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ovf        = 1'b0;
    unf        = 1'b0;
    case (bus.pc_op)
      OP_BR_ABS: begin
        if (cond) begin
          exec_pc    = bus.imm;
          exec_taken = 1'b1;
        end
      end
      OP_BR_REL: begin
        if (cond) begin
          exec_pc    = bus.current_pc + bus.imm;
          exec_taken = 1'b1;
        end
      end
      OP_CALL: begin
        if (!stack_full) begin
          exec_pc    = bus.imm;
          exec_taken = 1'b1;
          do_push    = 1'b1;
        end else begin
          ovf = 1'b1;
        end
      end
      OP_RET: begin
        if (!stack_empty) begin
          exec_pc    = stack_mem[pop_idx];
          exec_taken = 1'b1;
          do_pop     = 1'b1;
        end else begin
          unf = 1'b1;
        end
      end
      default: begin
        exec_pc    = seq_pc;
        exec_taken = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_pc_q <= '0;
      nzp_q     <= '0;
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      count_q   <= '0;
      fault_q   <= '0;
    end else begin
      valid_q <= exec_fire;
      if (exec_fire) begin
        next_pc_q <= exec_pc;
        taken_q   <= exec_taken;
        if (do_push) begin
          count_q <= count_q + SP_WIDTH'(1);
        end else if (do_pop) begin
          count_q <= count_dec;
        end
        fault_q <= fault_q | {unf, ovf};
      end
      if (upd_fire) begin
        nzp_q <= {flag_n, flag_z, flag_p};
      end
    end
  end

  // Entry contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (exec_fire && do_push) begin
      stack_mem[push_idx] <= seq_pc;
    end
  end

  assign bus.next_pc       = next_pc_q;
  assign bus.nzp_flags     = nzp_q;
  assign bus.next_pc_valid = valid_q;
  assign bus.branch_taken  = taken_q;
  assign bus.stack_count   = count_q;
  assign bus.fault         = fault_q;

endmodule
